// File: rtl/bram_delay_sync_if.sv
// Handshake bundle for the sync-pulse delay: enable and sync in, delayed sync and status out.
interface bram_delay_sync_if;
    logic       ce;
    logic       sync_in;
    logic       sync_out;
    logic       busy;
    logic       overrun;
    logic [7:0] overrun_cnt;

    modport master (
        output ce, sync_in,
        input  sync_out, busy, overrun, overrun_cnt
    );

    modport slave (
        input  ce, sync_in,
        output sync_out, busy, overrun, overrun_cnt
    );
endinterface

// File: rtl/bram_delay_sync.sv
// Regenerates the frame sync pulse DELAY ce-cycles later, tracking the BRAM data delay line.
// state  | meaning
// IDLE   | no pulse pending
// COUNT  | pulse pending, count = ce-cycles left until fire
module bram_delay_sync #(
    parameter int    DELAY     = 128,
    parameter int    CTR_WIDTH = 16,
    parameter string RETRIGGER = "RESTART"
) (
    input  logic               clk,
    input  logic               rst,
    bram_delay_sync_if.slave   sif
);

    logic       sync_out_q;
    logic       busy_w;
    logic       overrun_q;
    logic [7:0] ovr_cnt_q;

    if (DELAY < 1 || CTR_WIDTH < 1 || (longint'(DELAY) - 1) >= (longint'(1) << CTR_WIDTH)) begin : g_bad_delay
        $error("bram_delay_sync: DELAY-1 must fit in CTR_WIDTH bits and DELAY must be >= 1");
    end

    if (RETRIGGER != "RESTART" && RETRIGGER != "IGNORE") begin : g_bad_retrigger
        $error("bram_delay_sync: RETRIGGER must be RESTART or IGNORE");
    end

    if (DELAY == 1) begin : g_direct
        logic sync_out_d;

        always_comb begin
            sync_out_d = sif.sync_in & sif.ce;
        end

        always_ff @(posedge clk) begin
            if (rst) sync_out_q <= 1'b0;
            else     sync_out_q <= sync_out_d;
        end

        assign busy_w    = 1'b0;
        assign overrun_q = 1'b0;
        assign ovr_cnt_q = 8'd0;
    end else begin : g_fsm
        typedef enum logic {S_IDLE, S_COUNT} state_t;

        localparam bit                   RESTART_MODE = (RETRIGGER == "RESTART");
        localparam logic [CTR_WIDTH-1:0] RELOAD       = CTR_WIDTH'(DELAY - 1);
        localparam logic [CTR_WIDTH-1:0] ONE          = CTR_WIDTH'(1);

        state_t               state_q, state_d;
        logic [CTR_WIDTH-1:0] count_q, count_d;
        logic                 sync_out_d;
        logic                 overrun_d;
        logic [7:0]           ovr_cnt_d;
        logic                 accept;

        always_comb begin
            state_d    = state_q;
            count_d    = count_q;
            sync_out_d = 1'b0;
            overrun_d  = 1'b0;
            accept     = sif.sync_in & sif.ce;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        count_d = RELOAD;
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (sif.ce) begin
                        if (count_q == ONE) begin
                            // a sync landing on the fire cycle is a clean back-to-back frame
                            sync_out_d = 1'b1;
                            if (accept) begin
                                count_d = RELOAD;
                            end else begin
                                count_d = '0;
                                state_d = S_IDLE;
                            end
                        end else if (accept) begin
                            overrun_d = 1'b1;
                            count_d   = RESTART_MODE ? RELOAD : count_q - ONE;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase

            ovr_cnt_d = ovr_cnt_q;
            if (overrun_d && ovr_cnt_q != 8'hFF) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= S_IDLE;
                count_q    <= '0;
                sync_out_q <= 1'b0;
                overrun_q  <= 1'b0;
                ovr_cnt_q  <= 8'd0;
            end else begin
                state_q    <= state_d;
                count_q    <= count_d;
                sync_out_q <= sync_out_d;
                overrun_q  <= overrun_d;
                ovr_cnt_q  <= ovr_cnt_d;
            end
        end

        assign busy_w = (state_q == S_COUNT);
    end

    assign sif.sync_out    = sync_out_q;
    assign sif.busy        = busy_w;
    assign sif.overrun     = overrun_q;
    assign sif.overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_bram_delay_sync.sv
// Directed bench: five parameterisations share one stimulus stream; expectations come from a check table.
module tb_bram_delay_sync;

    localparam int NDUT  = 5;
    localparam int MAXC  = 320;
    localparam int S_OUT = 0, S_BUSY = 1, S_OVR = 2, S_CNT = 3, S_NOUT = 4, S_NOVR = 5;

    typedef struct {
        int    scen;
        int    dut;
        int    sig;
        int    cyc;
        int    exp;
        string name;
    } chk_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b0;
    logic sync_in = 1'b0;

    always #5 clk = ~clk;

    bram_delay_sync_if if0 ();
    bram_delay_sync_if if1 ();
    bram_delay_sync_if if2 ();
    bram_delay_sync_if if3 ();
    bram_delay_sync_if if4 ();

    assign if0.ce = ce; assign if0.sync_in = sync_in;
    assign if1.ce = ce; assign if1.sync_in = sync_in;
    assign if2.ce = ce; assign if2.sync_in = sync_in;
    assign if3.ce = ce; assign if3.sync_in = sync_in;
    assign if4.ce = ce; assign if4.sync_in = sync_in;

    bram_delay_sync #(.DELAY(128), .CTR_WIDTH(16), .RETRIGGER("RESTART")) u_d128 (.clk(clk), .rst(rst), .sif(if0));
    bram_delay_sync #(.DELAY(8),   .CTR_WIDTH(16), .RETRIGGER("RESTART")) u_d8r  (.clk(clk), .rst(rst), .sif(if1));
    bram_delay_sync #(.DELAY(8),   .CTR_WIDTH(4),  .RETRIGGER("IGNORE"))  u_d8i  (.clk(clk), .rst(rst), .sif(if2));
    bram_delay_sync #(.DELAY(1),   .CTR_WIDTH(16), .RETRIGGER("RESTART")) u_d1   (.clk(clk), .rst(rst), .sif(if3));
    bram_delay_sync #(.DELAY(2),   .CTR_WIDTH(16), .RETRIGGER("RESTART")) u_d2   (.clk(clk), .rst(rst), .sif(if4));

    logic [NDUT-1:0] w_out, w_busy, w_ovr;
    logic [7:0]      w_cnt [NDUT];

    assign w_out  = {if4.sync_out, if3.sync_out, if2.sync_out, if1.sync_out, if0.sync_out};
    assign w_busy = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    assign w_ovr  = {if4.overrun, if3.overrun, if2.overrun, if1.overrun, if0.overrun};
    assign w_cnt[0] = if0.overrun_cnt;
    assign w_cnt[1] = if1.overrun_cnt;
    assign w_cnt[2] = if2.overrun_cnt;
    assign w_cnt[3] = if3.overrun_cnt;
    assign w_cnt[4] = if4.overrun_cnt;

    int   cap [NDUT][4][MAXC];
    int   n_out [NDUT];
    int   n_ovr [NDUT];
    chk_t chks [$];
    int   total = 0;
    int   bad = 0;

    function automatic void add(int scen, int dut, int sig, int cyc, int exp, string name);
        chks.push_back('{scen, dut, sig, cyc, exp, name});
    endfunction

    // Scenario stimulus: which cycles carry sync_in, hold ce low, or pulse rst.
    function automatic bit sync_at(int scen, int cyc);
        case (scen)
            0: return cyc == 10;
            1: return cyc == 0 || cyc == 25;
            2: return (cyc % 8 == 0) && cyc <= 40;
            3: return cyc == 0 || cyc == 3;
            4: return cyc == 0;
            5: return cyc < 310;
            6: return cyc == 0 || cyc == 1 || cyc == 5;
            7: return cyc == 0 || cyc == 7;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ce_at(int scen, int cyc);
        if (scen == 1 && cyc >= 20 && cyc <= 29) return 1'b0;
        if (scen == 6 && cyc == 5) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit rst_at(int scen, int cyc);
        return scen == 4 && cyc == 4;
    endfunction

    task automatic run(input int scen, input int ncyc);
        rst = 1'b1; ce = 1'b0; sync_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            n_out[d] = 0;
            n_ovr[d] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int d = 0; d < NDUT; d++) begin
                cap[d][S_OUT][c]  = int'(w_out[d]);
                cap[d][S_BUSY][c] = int'(w_busy[d]);
                cap[d][S_OVR][c]  = int'(w_ovr[d]);
                cap[d][S_CNT][c]  = int'(w_cnt[d]);
                n_out[d] += int'(w_out[d]);
                n_ovr[d] += int'(w_ovr[d]);
            end
            sync_in = sync_at(scen, c);
            ce      = ce_at(scen, c);
            rst     = rst_at(scen, c);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; sync_in = 1'b0;
        foreach (chks[i]) begin
            if (chks[i].scen == scen) begin
                int act;
                case (chks[i].sig)
                    S_NOUT:  act = n_out[chks[i].dut];
                    S_NOVR:  act = n_ovr[chks[i].dut];
                    default: act = cap[chks[i].dut][chks[i].sig][chks[i].cyc];
                endcase
                total++;
                if (act != chks[i].exp) begin
                    bad++;
                    $display("FAIL %s (scen %0d dut %0d cyc %0d): got %0d expected %0d",
                             chks[i].name, scen, chks[i].dut, chks[i].cyc, act, chks[i].exp);
                end
            end
        end
    endtask

    initial begin
        // scen 0: DELAY=128 single sync at 10, plus reset state at cycle 0
        add(0, 0, S_OUT,  0,   0, "rst_out");
        add(0, 0, S_BUSY, 0,   0, "rst_busy");
        add(0, 0, S_OVR,  0,   0, "rst_ovr");
        add(0, 0, S_CNT,  0,   0, "rst_cnt");
        add(0, 0, S_BUSY, 10,  0, "d128_busy_before");
        add(0, 0, S_BUSY, 11,  1, "d128_busy_start");
        add(0, 0, S_BUSY, 137, 1, "d128_busy_late");
        add(0, 0, S_OUT,  137, 0, "d128_early");
        add(0, 0, S_OUT,  138, 1, "d128_fire");
        add(0, 0, S_BUSY, 139, 0, "d128_busy_end");
        add(0, 0, S_NOUT, 0,   1, "d128_pulses");
        // scen 1: ce low 20..29 stretches the delay, sync at 25 ignored
        add(1, 0, S_OUT,  128, 0, "ce_no_early");
        add(1, 0, S_OUT,  138, 1, "ce_fire");
        add(1, 0, S_NOUT, 0,   1, "ce_pulses");
        add(1, 1, S_NOUT, 0,   1, "ce_d8_pulses");
        add(1, 3, S_OUT,  26,  0, "ce_d1_gate");
        add(1, 3, S_NOUT, 0,   1, "ce_d1_pulses");
        // scen 2: periodic sync every 8 with DELAY=8
        add(2, 1, S_OUT,  8,  1, "per_fire8");
        add(2, 1, S_OUT,  9,  0, "per_gap9");
        add(2, 1, S_OUT,  48, 1, "per_fire48");
        add(2, 1, S_NOUT, 0,  6, "per_pulses_r");
        add(2, 1, S_NOVR, 0,  0, "per_novr_r");
        add(2, 2, S_NOUT, 0,  6, "per_pulses_i");
        add(2, 2, S_NOVR, 0,  0, "per_novr_i");
        // scen 3: sync at 0 and 3, RESTART vs IGNORE
        add(3, 1, S_OUT,  8,  0, "rs_no_old");
        add(3, 1, S_OUT,  11, 1, "rs_fire");
        add(3, 1, S_NOUT, 0,  1, "rs_pulses");
        add(3, 1, S_OVR,  4,  1, "rs_ovr");
        add(3, 1, S_NOVR, 0,  1, "rs_novr");
        add(3, 1, S_CNT,  20, 1, "rs_cnt");
        add(3, 2, S_OUT,  8,  1, "ig_fire");
        add(3, 2, S_NOUT, 0,  1, "ig_pulses");
        add(3, 2, S_OVR,  4,  1, "ig_ovr");
        add(3, 2, S_CNT,  20, 1, "ig_cnt");
        // scen 4: reset mid-count drops the pending pulse
        add(4, 1, S_BUSY, 4,  1, "mid_busy");
        add(4, 1, S_BUSY, 5,  0, "mid_busy_clr");
        add(4, 1, S_NOUT, 0,  0, "mid_pulses");
        // scen 5: sync held high, overrun_cnt saturates
        add(5, 1, S_CNT,  1,   0, "sat_cnt1");
        add(5, 1, S_CNT,  100, 99, "sat_cnt100");
        add(5, 1, S_CNT,  256, 255, "sat_cnt256");
        add(5, 1, S_CNT,  319, 255, "sat_hold");
        add(5, 1, S_OVR,  300, 1, "sat_ovr");
        add(5, 4, S_OUT,  100, 1, "d2_hold_out");
        add(5, 4, S_NOVR, 0,   0, "d2_hold_novr");
        // scen 6: DELAY=1 passthrough and DELAY=2 latency; counter cleared by reset
        add(6, 1, S_CNT,  0, 0, "cnt_cleared");
        add(6, 3, S_OUT,  1, 1, "d1_out1");
        add(6, 3, S_OUT,  2, 1, "d1_out2");
        add(6, 3, S_OUT,  3, 0, "d1_out3");
        add(6, 3, S_OUT,  6, 0, "d1_ce_gate");
        add(6, 3, S_BUSY, 2, 0, "d1_busy");
        add(6, 4, S_OUT,  1, 0, "d2_early");
        add(6, 4, S_OUT,  2, 1, "d2_fire");
        add(6, 4, S_OUT,  3, 1, "d2_b2b");
        add(6, 4, S_BUSY, 1, 1, "d2_busy");
        add(6, 4, S_NOVR, 0, 0, "d2_novr");
        // scen 7: sync on the fire cycle is a clean handoff in both modes
        add(7, 1, S_OUT,  8,  1, "h_fire_r");
        add(7, 1, S_OUT,  15, 1, "h_fire2_r");
        add(7, 1, S_BUSY, 8,  1, "h_busy_r");
        add(7, 1, S_NOVR, 0,  0, "h_novr_r");
        add(7, 2, S_OUT,  15, 1, "h_fire2_i");
        add(7, 2, S_NOVR, 0,  0, "h_novr_i");

        run(0, 150);
        run(1, 150);
        run(2, 60);
        run(3, 30);
        run(4, 20);
        run(5, 320);
        run(6, 12);
        run(7, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
